// File: rtl/usb_reg_arbiter_if.sv
// Register-bus bundle seen by usb_reg_arbiter: USB front-end side, internal
// master side and register-decode side. slave = arbiter view, master = environment view.
interface usb_reg_arbiter_if #(
  parameter int pBYTECNT_SIZE = 7
);
  // USB register front-end
  logic [7:0]               usb_address;
  logic [pBYTECNT_SIZE-1:0] usb_bytecnt;
  logic [7:0]               usb_datao;
  logic                     usb_read;
  logic                     usb_write;
  logic                     usb_addrvalid;
  logic [7:0]               usb_datai;

  // Internal master
  logic                     int_req;
  logic                     int_wr;
  logic [7:0]               int_address;
  logic [pBYTECNT_SIZE-1:0] int_bytecnt;
  logic [7:0]               int_wdata;
  logic                     int_gnt;
  logic                     int_done;
  logic                     int_err;
  logic [7:0]               int_rdata;

  // Register decode
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               reg_datao;
  logic                     reg_read;
  logic                     reg_write;
  logic                     reg_addrvalid;
  logic [7:0]               reg_datai;

  modport slave (
    input  usb_address, usb_bytecnt, usb_datao, usb_read, usb_write, usb_addrvalid,
    output usb_datai,
    input  int_req, int_wr, int_address, int_bytecnt, int_wdata,
    output int_gnt, int_done, int_err, int_rdata,
    output reg_address, reg_bytecnt, reg_datao, reg_read, reg_write, reg_addrvalid,
    input  reg_datai
  );

  modport master (
    output usb_address, usb_bytecnt, usb_datao, usb_read, usb_write, usb_addrvalid,
    input  usb_datai,
    output int_req, int_wr, int_address, int_bytecnt, int_wdata,
    input  int_gnt, int_done, int_err, int_rdata,
    input  reg_address, reg_bytecnt, reg_datao, reg_read, reg_write, reg_addrvalid,
    output reg_datai
  );
endinterface

// File: rtl/usb_reg_arbiter.sv
// Shares the 8-bit register bus between USB (always wins, never stalled) and one
// internal master. Define REG_ARB_INT_WRITE_EN to allow internal writes; otherwise they are rejected.
module usb_reg_arbiter #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pIDLE_GUARD   = 4
) (
  input logic               cwusb_clk,
  input logic               resetn,
  usb_reg_arbiter_if.slave  bus
);

`ifdef REG_ARB_INT_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  localparam logic [3:0] GUARD_LAST = 4'(pIDLE_GUARD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GUARD,
    S_SETUP,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] guard_cnt_q, guard_cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  logic usb_busy;
  logic int_phase;
  logic int_own;
  logic reject_wr;

  assign usb_busy  = bus.usb_read | bus.usb_write | ~bus.usb_addrvalid;
  assign int_phase = (state_q == S_SETUP) | (state_q == S_ACCESS) | (state_q == S_CAPTURE);
  // Combinational on usb_busy so a USB access takes the bus in the very cycle it appears.
  assign int_own   = int_phase & ~usb_busy;
  assign reject_wr = bus.int_wr & ~WR_EN;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.int_req) begin
          if (reject_wr) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            // The request cycle itself counts as the first idle cycle of the window.
            state_d     = S_GUARD;
            guard_cnt_d = usb_busy ? 4'd0 : 4'd1;
          end
        end
      end
      S_GUARD: begin
        if (!bus.int_req) begin
          state_d     = S_IDLE;
          guard_cnt_d = 4'd0;
        end else if (usb_busy) begin
          guard_cnt_d = 4'd0;
        end else if (guard_cnt_q >= GUARD_LAST) begin
          state_d     = S_SETUP;
          guard_cnt_d = 4'd0;
        end else begin
          guard_cnt_d = guard_cnt_q + 4'd1;
        end
      end
      S_SETUP: begin
        if (usb_busy) begin
          state_d     = S_GUARD;
          guard_cnt_d = 4'd0;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (usb_busy) begin
          state_d     = S_GUARD;
          guard_cnt_d = 4'd0;
        end else begin
          state_d = bus.int_wr ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (usb_busy) begin
          state_d     = S_GUARD;
          guard_cnt_d = 4'd0;
        end else begin
          rdata_d = bus.reg_datai;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge cwusb_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      guard_cnt_q <= 4'd0;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  logic [7:0]               address_mux;
  logic [pBYTECNT_SIZE-1:0] bytecnt_mux;
  logic [7:0]               datao_mux;
  logic                     read_mux;
  logic                     write_mux;
  logic                     addrvalid_mux;

  always_comb begin
    address_mux   = bus.usb_address;
    bytecnt_mux   = bus.usb_bytecnt;
    datao_mux     = bus.usb_datao;
    read_mux      = bus.usb_read;
    write_mux     = bus.usb_write;
    addrvalid_mux = bus.usb_addrvalid;
    if (int_own) begin
      address_mux   = bus.int_address;
      bytecnt_mux   = bus.int_bytecnt;
      datao_mux     = bus.int_wdata;
      addrvalid_mux = (state_q != S_SETUP);
      read_mux      = (state_q == S_ACCESS) & ~bus.int_wr;
      write_mux     = (state_q == S_ACCESS) & bus.int_wr & WR_EN;
    end
  end

  assign bus.reg_address   = address_mux;
  assign bus.reg_bytecnt   = bytecnt_mux;
  assign bus.reg_datao     = datao_mux;
  assign bus.reg_read      = read_mux;
  assign bus.reg_write     = write_mux;
  assign bus.reg_addrvalid = addrvalid_mux;

  assign bus.usb_datai = bus.reg_datai;
  assign bus.int_done  = (state_q == S_DONE);
  assign bus.int_err   = err_q;
  // A rejected write never touches the bus, so it is not reported as a grant.
  assign bus.int_gnt   = (int_phase | (state_q == S_DONE)) & ~err_q;
  assign bus.int_rdata = rdata_q;

endmodule
